// File: rtl/lfsr_bank_if.sv
// Output stream bundle of lfsr_bank: word bus plus valid/ready handshake.
// The producer drives the word and valid; the consumer drives ready.
interface lfsr_bank_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4
);
    logic [NUM_CH*WIDTH-1:0] o_Data;
    logic                    o_Valid;
    logic                    i_Ready;

    modport master (
        output o_Data,
        output o_Valid,
        input  i_Ready
    );

    modport slave (
        input  o_Data,
        input  o_Valid,
        output i_Ready
    );
endinterface

// File: rtl/lfsr_bank.sv
// Multi-channel Fibonacci LFSR random-word generator with leap-ahead,
// runtime seed loading, zero-state protection and a valid/ready output.
module lfsr_bank #(
    parameter int              WIDTH        = 32,
    parameter int              NUM_CH       = 4,
    parameter logic [WIDTH-1:0] TAPS        = 32'h8020_0003,
    parameter int              STEP         = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h0000_0001,
    localparam int             CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Enable,
    input  logic             i_Seed_Valid,
    input  logic [CHW-1:0]   i_Seed_Ch,
    input  logic [WIDTH-1:0] i_Seed_Data,
    lfsr_bank_if.master      bus,
    output logic             o_Zero_Fix,
    output logic [31:0]      o_Count
);

    logic [WIDTH-1:0]        state_q [NUM_CH];
    logic [WIDTH-1:0]        state_d [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    fix_q, fix_d;
    logic [31:0]             count_q, count_d;
    logic                    produce;

    function automatic logic [WIDTH-1:0] adv_n(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < STEP; i++) begin
            t = {t[WIDTH-2:0], ^(t & TAPS)};
        end
        return t;
    endfunction

    // Per-channel reset seeds are decorrelated with a golden-ratio stride.
    function automatic logic [WIDTH-1:0] rst_seed(input int c);
        logic [31:0]      m;
        logic [63:0]      x;
        logic [WIDTH-1:0] s;
        m = 32'(c) * 32'h9E37_79B9;
        x = {32'b0, m};
        s = DEFAULT_SEED ^ x[WIDTH-1:0];
        return (s == '0) ? DEFAULT_SEED : s;
    endfunction

    always_comb begin
        produce = i_Enable & ~i_Seed_Valid & (~valid_q | bus.i_Ready);
        data_d  = data_q;
        fix_d   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            if (produce) begin
                data_d[c*WIDTH +: WIDTH] = state_q[c];
                state_d[c] = adv_n(state_q[c]);
            end
            if (i_Seed_Valid && (32'(i_Seed_Ch) == 32'(c))) begin
                state_d[c] = i_Seed_Data;
            end
            // A zero seed or a lock-up state is never allowed to land.
            if (state_d[c] == '0) begin
                state_d[c] = DEFAULT_SEED;
                fix_d      = 1'b1;
            end
        end

        valid_d = valid_q;
        if (i_Seed_Valid) begin
            valid_d = 1'b0;
        end else if (produce) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.i_Ready) begin
            valid_d = 1'b0;
        end

        count_d = count_q
                + 32'(valid_q & bus.i_Ready & ~i_Seed_Valid);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= rst_seed(c);
            end
            data_q  <= '0;
            valid_q <= 1'b0;
            fix_q   <= 1'b0;
            count_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
            end
            data_q  <= data_d;
            valid_q <= valid_d;
            fix_q   <= fix_d;
            count_q <= count_d;
        end
    end

    assign bus.o_Data  = data_q;
    assign bus.o_Valid = valid_q;
    assign o_Zero_Fix  = fix_q;
    assign o_Count     = count_q;

endmodule

// File: tb/tb_lfsr_bank.sv
// Bench for lfsr_bank: an 8-bit 4-channel STEP=1 instance and an 8-bit
// single-channel STEP=3 instance, checked against a word-index model.
module tb_lfsr_bank;

    logic       clk = 1'b0;
    logic       rst, en, rdy, sv;
    logic [1:0] ch;
    logic       chB;
    logic [7:0] sd;
    logic       zfA, zfB;
    logic [31:0] cntA, cntB;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lfsr_bank_if #(.WIDTH(8), .NUM_CH(4)) busA ();
    lfsr_bank_if #(.WIDTH(8), .NUM_CH(1)) busB ();

    assign busA.i_Ready = rdy;
    assign busB.i_Ready = rdy;

    lfsr_bank #(
        .WIDTH(8), .NUM_CH(4), .TAPS(8'hB8), .STEP(1), .DEFAULT_SEED(8'h01)
    ) dutA (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_Valid(sv),
        .i_Seed_Ch(ch), .i_Seed_Data(sd), .bus(busA),
        .o_Zero_Fix(zfA), .o_Count(cntA)
    );

    lfsr_bank #(
        .WIDTH(8), .NUM_CH(1), .TAPS(8'hB8), .STEP(3), .DEFAULT_SEED(8'h01)
    ) dutB (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_Valid(sv),
        .i_Seed_Ch(chB), .i_Seed_Data(sd), .bus(busB),
        .o_Zero_Fix(zfB), .o_Count(cntB)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: word k of a channel is the seed advanced k*STEP times.
    function automatic logic [7:0] lfsr_word(input logic [7:0] seed, input int n);
        logic [7:0] s;
        s = seed;
        for (int i = 0; i < n; i++) begin
            s = 8'((s << 1) | 8'($countones(s & 8'hB8) % 2));
        end
        return s;
    endfunction

    function automatic logic [7:0] reset_seed(input int c);
        logic [31:0] m;
        logic [7:0]  s;
        m = 32'(c) * 32'h9E37_79B9;
        s = 8'h01 ^ m[7:0];
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    logic [7:0]  m_seed [2][4];
    int          m_k    [2][4];
    logic [7:0]  m_data [2][4];
    logic        m_valid[2];
    logic [31:0] m_cnt  [2];
    logic        m_fix  [2];
    bit          armed = 1'b0;
    int          nch [2] = '{4, 1};
    int          stp [2] = '{1, 3};

    task automatic model_step();
        bit p;
        int tgt;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int c = 0; c < 4; c++) begin
                    m_seed[d][c] = reset_seed(c);
                    m_k[d][c]    = 0;
                    m_data[d][c] = 8'h00;
                end
                m_valid[d] = 1'b0;
                m_cnt[d]   = 32'd0;
                m_fix[d]   = 1'b0;
            end else begin
                p = en && !sv && (!m_valid[d] || rdy);
                m_fix[d] = 1'b0;
                if (m_valid[d] && rdy && !sv) m_cnt[d] = m_cnt[d] + 1;
                if (p) begin
                    for (int c = 0; c < nch[d]; c++) begin
                        m_data[d][c] = lfsr_word(m_seed[d][c], m_k[d][c] * stp[d]);
                        m_k[d][c]++;
                    end
                end
                if (sv) begin
                    tgt = (d == 0) ? int'(ch) : 0;
                    m_seed[d][tgt] = (sd == 8'h00) ? 8'h01 : sd;
                    m_k[d][tgt]    = 0;
                    m_fix[d]       = (sd == 8'h00);
                    m_valid[d]     = 1'b0;
                end else if (p) begin
                    m_valid[d] = 1'b1;
                end else if (m_valid[d] && rdy) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
        if (rst) armed = 1'b1;
    endtask

    initial begin
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int c = 0; c < 4; c++) ea[c*8 +: 8] = m_data[0][c];
                check("A.data", busA.o_Data, ea);
                check("A.valid", 32'(busA.o_Valid), 32'(m_valid[0]));
                check("A.count", cntA, m_cnt[0]);
                check("A.zfix", 32'(zfA), 32'(m_fix[0]));
                check("B.data", 32'(busB.o_Data), 32'(m_data[1][0]));
                check("B.valid", 32'(busB.o_Valid), 32'(m_valid[1]));
                check("B.count", cntB, m_cnt[1]);
                check("B.zfix", 32'(zfB), 32'(m_fix[1]));
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] lit7 [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    logic [7:0] lit3 [3] = '{8'h01, 8'h08, 8'h47};
    logic [7:0] w [256];

    initial begin
        int nd, nz;
        bit seen [256];
        rst = 1'b1; en = 1'b0; rdy = 1'b0; sv = 1'b0;
        ch = 2'd0; chB = 1'b0; sd = 8'h00;
        repeat (3) tick();
        rst = 1'b0; en = 1'b1; rdy = 1'b1;

        for (int i = 0; i < 256; i++) begin
            tick();
            w[i] = busA.o_Data[7:0];
            if (i < 7) check("lit.step1", 32'(w[i]), 32'(lit7[i]));
            if (i < 3) check("lit.step3", 32'(busB.o_Data), 32'(lit3[i]));
            if (i == 0) begin
                check("lit.seed1", 32'(busA.o_Data[15:8]), 32'h B8);
                check("lit.seed2", 32'(busA.o_Data[23:16]), 32'h 73);
                check("lit.seed3", 32'(busA.o_Data[31:24]), 32'h 2A);
            end
            if (i == 6) check("lit.count", cntA, 32'd6);
        end
        check("period.wrap", 32'(w[255]), 32'h01);
        nd = 0; nz = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 255; i++) begin
            if (w[i] == 8'h00) nz++;
            else if (!seen[w[i]]) begin
                seen[w[i]] = 1'b1;
                nd++;
            end
        end
        check("period.nozero", 32'(nz), 32'd0);
        check("period.distinct", 32'(nd), 32'd255);

        rdy = 1'b0;
        repeat (5) tick();
        rdy = 1'b1;
        repeat (3) tick();

        sv = 1'b1; ch = 2'd2; sd = 8'h5A;
        tick();
        check("seed.flush", 32'(busA.o_Valid), 32'd0);
        sv = 1'b0;
        tick();
        check("seed.ch2", 32'(busA.o_Data[23:16]), 32'h5A);
        check("seed.valid", 32'(busA.o_Valid), 32'd1);

        sv = 1'b1; ch = 2'd1; sd = 8'h00;
        tick();
        check("zfix.pulse", 32'(zfA), 32'd1);
        sv = 1'b0;
        tick();
        check("zfix.once", 32'(zfA), 32'd0);
        check("zfix.ch1", 32'(busA.o_Data[15:8]), 32'h01);

        for (int i = 0; i < 40; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            rdy = $urandom_range(0, 1) == 1;
            sv  = (i % 13 == 5);
            ch  = 2'($urandom_range(0, 3));
            sd  = 8'($urandom_range(0, 255));
            tick();
        end
        en = 1'b1; rdy = 1'b1; sv = 1'b0;
        repeat (3) tick();

        rdy = 1'b0;
        repeat (2) tick();
        rst = 1'b1; sv = 1'b1; ch = 2'd3; sd = 8'h77;
        tick();
        check("rst.valid", 32'(busA.o_Valid), 32'd0);
        check("rst.count", cntA, 32'd0);
        rst = 1'b0; sv = 1'b0; rdy = 1'b1; en = 1'b1;
        tick();
        check("rst.ch0", 32'(busA.o_Data[7:0]), 32'h01);
        check("rst.ch3", 32'(busA.o_Data[31:24]), 32'h2A);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
